ysyx_22050612_dmem_responder: RTL and testbench

Data-memory responder at the far end of the execution unit's load/store path. It accepts one read or byte-masked write request at a time over a valid/ready request channel, services it from an internal word-addressed SRAM after a programmable latency, and returns a response over a valid/ready response channel. It replaces the zero-latency simulation memory with synthesizable storage and realistic handshakes for the multi-cycle core.

---
 rtl/ysyx_22050612_mem_pkg.sv | 26 ++
 rtl/ysyx_22050612_dmem_responder_if.sv | 31 +++
 rtl/ysyx_22050612_sram_1rw.sv | 36 +++
 rtl/ysyx_22050612_dmem_responder.sv | 124 ++++++++++++
 tb/tb_ysyx_22050612_dmem_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types for the data-memory responder.
// States, request/response bundles and bus widths.
package ysyx_22050612_mem_pkg;

  localparam int XLEN  = 64;
  localparam int MASKW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             wen;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [MASKW-1:0] wmask;
  } req_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } rsp_t;

endpackage

// File: rtl/ysyx_22050612_dmem_responder_if.sv
// Request/response channel between the LSU and the
// data-memory responder.
interface ysyx_22050612_dmem_responder_if;
  import ysyx_22050612_mem_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_wen;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic [MASKW-1:0] req_wmask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/ysyx_22050612_sram_1rw.sv
// Single-port byte-masked 64-bit SRAM, registered read.
// Contents are deliberately not reset.
module ysyx_22050612_sram_1rw
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [MASKW-1:0]      wmask,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < MASKW; i++) begin
          if (wmask[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder: one outstanding request,
// programmable access latency, registered handshakes.
module ysyx_22050612_dmem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050612_dmem_responder_if.slave bus
);

  localparam logic [63:0] WIN = 64'd8 << DEPTH_LOG2;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rd_ok_q, rd_ok_d;

  logic [63:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_lo;
  logic                  sram_en;
  logic                  sram_we;
  logic [XLEN-1:0]       sram_rdata;
  rsp_t                  rsp;

  // Unsigned window check; addresses below the base never wrap in.
  assign offset    = req_q.addr - BASE_ADDR;
  assign in_range  = (req_q.addr >= BASE_ADDR) && (offset < WIN);
  assign idx       = offset[DEPTH_LOG2+2:3];
  assign unused_lo = ^offset[2:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rsp_err_d = rsp_err_q;
    rd_ok_d   = rd_ok_q;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_d.wen   = bus.req_wen;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          req_d.wmask = bus.req_wmask;
          cnt_d       = 4'(LATENCY);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sram_en   = in_range;
          sram_we   = req_q.wen;
          rsp_err_d = !in_range;
          rd_ok_d   = in_range && !req_q.wen;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_err_d = 1'b0;
          rd_ok_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  ysyx_22050612_sram_1rw #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (idx),
    .wdata(req_q.wdata),
    .wmask(req_q.wmask),
    .rdata(sram_rdata)
  );

  // Read data is only exposed for a successful read response.
  assign rsp.rdata = rd_ok_q ? sram_rdata : '0;
  assign rsp.err   = rsp_err_q;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp.rdata;
  assign bus.rsp_err   = rsp.err;

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// Bench for the data-memory responder: directed table,
// corner sequences and random traffic against a word model.
module tb_ysyx_22050612_dmem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] WIN  = 64'd8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050612_dmem_responder_if m2 ();
  ysyx_22050612_dmem_responder_if m0 ();

  ysyx_22050612_dmem_responder #(
    .DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));

  ysyx_22050612_dmem_responder #(
    .DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));

  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] mm [int];

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic void ref_op(
    input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
    input logic [7:0] wmask, output logic [63:0] rd, output logic err);
    int idx;
    logic [63:0] w;
    rd = '0;
    err = 1'b0;
    if (addr < BASE || addr >= BASE + WIN) begin
      err = 1'b1;
      return;
    end
    idx = int'((addr - BASE) / 8);
    if (wen) begin
      w = mm.exists(idx) ? mm[idx] : 64'd0;
      for (int b = 0; b < 8; b++)
        if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
      mm[idx] = w;
    end else begin
      rd = mm[idx];
    end
  endfunction

  task automatic issue(input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       output int lat);
    int n;
    m2.req_wen = wen;
    m2.req_addr = addr;
    m2.req_wdata = wdata;
    m2.req_wmask = wmask;
    m2.req_valid = 1'b1;
    n = 0;
    while (!m2.req_ready && n < 20) begin tick(); n++; end
    tick();
    m2.req_valid = 1'b0;
    lat = 0;
    while (!m2.rsp_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic xact(input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      output logic [63:0] rd, output logic err,
                      output int lat);
    issue(wen, addr, wdata, wmask, lat);
    rd = m2.rsp_rdata;
    err = m2.rsp_err;
    m2.rsp_ready = 1'b1;
    tick();
    m2.rsp_ready = 1'b0;
    chk("ready_after_rsp", 64'(m2.req_ready), 64'd1);
  endtask

  initial begin
    vec_t vt [$];
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    logic [63:0] d0;

    m2.req_valid = 0; m2.req_wen = 0; m2.req_addr = 0;
    m2.req_wdata = 0; m2.req_wmask = 0; m2.rsp_ready = 0;
    m0.req_valid = 0; m0.req_wen = 0; m0.req_addr = 0;
    m0.req_wdata = 0; m0.req_wmask = 0; m0.rsp_ready = 0;

    tick(); tick();
    chk("rst_req_ready", 64'(m2.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(m2.rsp_valid), 64'd0);
    chk("rst_rdata", m2.rsp_rdata, 64'd0);
    chk("rst_err", 64'(m2.rsp_err), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(m2.req_ready), 64'd1);

    vt.push_back('{1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 0});
    vt.push_back('{0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 0});
    vt.push_back('{1, 64'h8000_0010, 64'h0000_00AB_0000_0000, 8'h10, 64'h0, 0});
    vt.push_back('{0, 64'h8000_0013, 64'h0, 8'h00, 64'h112233AB55667788, 0});
    vt.push_back('{1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1});
    vt.push_back('{0, 64'h8000_2000, 64'h0, 8'h00, 64'h0, 1});
    vt.push_back('{0, 64'h8000_0010, 64'h0, 8'h00, 64'h112233AB55667788, 0});
    vt.push_back('{1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 0});
    vt.push_back('{0, 64'h8000_0010, 64'h0, 8'h00, 64'h112233AB55667788, 0});
    vt.push_back('{1, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'h0, 0});
    vt.push_back('{1, 64'h8000_1FF8, 64'h0102030405060708, 8'hFF, 64'h0, 0});
    vt.push_back('{0, 64'h8000_1FF8, 64'h0, 8'h00, 64'h0102030405060708, 0});
    vt.push_back('{0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0, 1});

    foreach (vt[i]) begin
      xact(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, rd, err, lat);
      ref_op(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, erd, eerr);
      chk($sformatf("tab%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("tab%0d_err", i), 64'(err), 64'(vt[i].exp_err));
      chk($sformatf("tab%0d_lat", i), 64'(lat), 64'd3);
    end

    issue(0, 64'h8000_0010, 64'h0, 8'h00, lat);
    m2.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(m2.rsp_valid), 64'd1);
      chk("bp_rdata", m2.rsp_rdata, 64'h112233AB55667788);
      chk("bp_err", 64'(m2.rsp_err), 64'd0);
      chk("bp_req_ready", 64'(m2.req_ready), 64'd0);
      tick();
    end
    m2.req_valid = 1'b0;
    m2.rsp_ready = 1'b1;
    tick();
    m2.rsp_ready = 1'b0;
    chk("bp_ready_after", 64'(m2.req_ready), 64'd1);

    m2.req_wen = 1; m2.req_addr = 64'h8000_0020;
    m2.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; m2.req_wmask = 8'hFF;
    m2.req_valid = 1'b1;
    tick();
    m2.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstw_valid", 64'(m2.rsp_valid), 64'd0);
    chk("rstw_ready", 64'(m2.req_ready), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rstw_ready_rel", 64'(m2.req_ready), 64'd1);
    xact(0, 64'h8000_0020, 64'h0, 8'h00, rd, err, lat);
    chk("rstw_old_value", rd, 64'hCAFE_F00D_1234_5678);

    issue(0, 64'h8000_0010, 64'h0, 8'h00, lat);
    rst_n = 1'b0;
    #1;
    chk("rstr_valid", 64'(m2.rsp_valid), 64'd0);
    chk("rstr_rdata", m2.rsp_rdata, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 16; k++) begin
      d0 = {$urandom, $urandom};
      xact(1, BASE + 64'(8*k), d0, 8'hFF, rd, err, lat);
      ref_op(1, BASE + 64'(8*k), d0, 8'hFF, erd, eerr);
    end
    for (int k = 0; k < 40; k++) begin
      logic w;
      logic [63:0] a, wd;
      logic [7:0] wm;
      w = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      wm = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 64'd8;
          1: a = BASE + WIN;
          2: a = 64'hFFFF_FFFF_FFFF_FFF8;
          default: a = 64'd0;
        endcase
      end else begin
        a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      end
      xact(w, a, wd, wm, rd, err, lat);
      ref_op(w, a, wd, wm, erd, eerr);
      chk($sformatf("rnd%0d_rdata", k), rd, erd);
      chk($sformatf("rnd%0d_err", k), 64'(err), 64'(eerr));
      chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'd3);
    end

    d0 = 64'h0BAD_CAFE_5555_AAAA;
    m0.req_wen = 1; m0.req_addr = 64'h8000_0040;
    m0.req_wdata = d0; m0.req_wmask = 8'hFF;
    m0.rsp_ready = 1'b1;
    m0.req_valid = 1'b1;
    chk("l0_ready0", 64'(m0.req_ready), 64'd1);
    tick();
    m0.req_wen = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      chk("l0_valid", 64'(m0.rsp_valid), 64'(i % 3 == 2));
      if (i % 3 == 0) chk("l0_ready", 64'(m0.req_ready), 64'd1);
      if (i % 3 == 2) chk("l0_rdata", m0.rsp_rdata, (i == 2) ? 64'd0 : d0);
      tick();
    end
    m0.req_valid = 1'b0;
    tick(); tick(); tick();
    m0.rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
